// File: rtl/apa102_pkg.sv
// apa102_pkg: shared constants, types and helpers for the APA102 frame receiver.
//   FRAME_BITS / LED_HDR : word length and LED-frame header pattern.
//   *_MSB / *_LSB        : field positions inside a 32-bit LED word.
//   pixel_t              : decoded pixel {bright, blue, green, red}.
//   state_t              : receiver state {HUNT, LEDS}.
package apa102_pkg;

    localparam int         FRAME_BITS = 32;
    localparam logic [2:0] LED_HDR    = 3'b111;

    localparam int HDR_MSB    = 31;
    localparam int HDR_LSB    = 29;
    localparam int BRIGHT_MSB = 28;
    localparam int BRIGHT_LSB = 24;
    localparam int BLUE_MSB   = 23;
    localparam int BLUE_LSB   = 16;
    localparam int GREEN_MSB  = 15;
    localparam int GREEN_LSB  = 8;
    localparam int RED_MSB    = 7;
    localparam int RED_LSB    = 0;

    typedef struct packed {
        logic [4:0] bright;
        logic [7:0] blue;
        logic [7:0] green;
        logic [7:0] red;
    } pixel_t;

    typedef enum logic {
        HUNT = 1'b0,
        LEDS = 1'b1
    } state_t;

    function automatic logic has_led_hdr(input logic [FRAME_BITS-1:0] w);
        return w[HDR_MSB:HDR_LSB] == LED_HDR;
    endfunction

    function automatic pixel_t word_to_pixel(input logic [FRAME_BITS-1:0] w);
        pixel_t p;
        p.bright = w[BRIGHT_MSB:BRIGHT_LSB];
        p.blue   = w[BLUE_MSB:BLUE_LSB];
        p.green  = w[GREEN_MSB:GREEN_LSB];
        p.red    = w[RED_MSB:RED_LSB];
        return p;
    endfunction

endpackage

// File: rtl/apa102_edge_sync.sv
// apa102_edge_sync: brings the asynchronous strip clock and data into the clk
// domain through identical flop chains and flags each strip-clock rise.
//   clk, reset   : system clock, async active-low reset
//   i_led_clk    : raw strip clock
//   i_led_data   : raw strip data
//   o_data       : synced data bit, aligned with o_stb
//   o_stb        : one-cycle strobe per strip-clock rising edge
module apa102_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_led_clk,
    input  logic i_led_data,
    output logic o_data,
    output logic o_stb
);

    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_data_sync;
    logic                   r_clk_prev;
    logic                   r_stb;
    logic                   r_data;

    // Strobe and data are registered together so the bit presented with the
    // strobe is the one captured through the same chain depth as the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_clk_sync  <= '0;
            r_data_sync <= '0;
            r_clk_prev  <= 1'b0;
            r_stb       <= 1'b0;
            r_data      <= 1'b0;
        end else begin
            r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], i_led_clk};
            r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], i_led_data};
            r_clk_prev  <= r_clk_sync[SYNC_STAGES-1];
            r_stb       <= r_clk_sync[SYNC_STAGES-1] & ~r_clk_prev;
            r_data      <= r_data_sync[SYNC_STAGES-1];
        end
    end

    assign o_stb  = r_stb;
    assign o_data = r_data;

endmodule

// File: rtl/apa102_frame_rx.sv
// apa102_frame_rx: APA102 two-wire stream receiver. Finds the 32-zero start
// frame, decodes LED frames and presents one pixel per frame on valid/ready.
//   clk, reset            : system clock, async active-low reset (deassertion
//                           expected synchronous to clk from the reset source)
//   led_clk_i, led_data_i : serial strip clock / data (async to clk)
//   pix_valid, pix_ready  : pixel handshake
//   pix_index             : LED position within the refresh
//   pix_bright/blue/green/red : decoded fields
//   frame_done            : one-cycle pulse at end of a refresh
//   hdr_err, overflow     : sticky error flags, cleared by clear_err
module apa102_frame_rx
    import apa102_pkg::*;
#(
    parameter int NUM_LEDS    = 64,
    parameter int SYNC_STAGES = 2,
    localparam int IDX_W      = $clog2(NUM_LEDS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             led_clk_i,
    input  logic             led_data_i,
    output logic             pix_valid,
    input  logic             pix_ready,
    output logic [IDX_W-1:0] pix_index,
    output logic [4:0]       pix_bright,
    output logic [7:0]       pix_blue,
    output logic [7:0]       pix_green,
    output logic [7:0]       pix_red,
    output logic             frame_done,
    output logic             hdr_err,
    output logic             overflow,
    input  logic             clear_err
);

    logic w_bit;
    logic w_stb;

    apa102_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk        (clk),
        .reset      (reset),
        .i_led_clk  (led_clk_i),
        .i_led_data (led_data_i),
        .o_data     (w_bit),
        .o_stb      (w_stb)
    );

    state_t                  r_state, w_state_nxt;
    logic [FRAME_BITS-1:0]   r_shift;
    logic [4:0]              r_bitcnt;
    logic [5:0]              r_zrun;
    logic                    r_word_vld;
    logic [IDX_W-1:0]        r_idx;
    pixel_t                  r_pix;
    logic [IDX_W-1:0]        r_pix_idx;
    logic                    r_valid;
    logic                    r_done;
    logic                    r_hdr_err;
    logic                    r_ovf;

    logic w_start, w_load, w_done, w_hdr, w_idx_clr, w_idx_inc, w_hs;

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= HUNT;
        else        r_state <= w_state_nxt;
    end

    // Next state and control strobes. Words are evaluated one cycle after the
    // last bit lands in r_shift (r_word_vld), so the decode sees a full word.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_load      = 1'b0;
        w_done      = 1'b0;
        w_hdr       = 1'b0;
        w_idx_clr   = 1'b0;
        w_idx_inc   = 1'b0;
        case (r_state)
            HUNT: begin
                if (w_stb && !w_bit && r_zrun == 6'd31) begin
                    w_start     = 1'b1;
                    w_idx_clr   = 1'b1;
                    w_state_nxt = LEDS;
                end
            end
            LEDS: begin
                if (r_word_vld) begin
                    if (has_led_hdr(r_shift)) begin
                        w_load = 1'b1;
                        if (r_idx == IDX_W'(NUM_LEDS - 1)) begin
                            w_done      = 1'b1;
                            w_idx_clr   = 1'b1;
                            w_state_nxt = HUNT;
                        end else begin
                            w_idx_inc = 1'b1;
                        end
                    end else if (r_shift == '0) begin
                        // End frame or back-to-back start frame: realign index.
                        w_done    = (r_idx != '0);
                        w_idx_clr = 1'b1;
                    end else begin
                        w_hdr       = 1'b1;
                        w_idx_clr   = 1'b1;
                        w_state_nxt = HUNT;
                    end
                end
            end
            default: w_state_nxt = HUNT;
        endcase
    end

    // Shift register, bit counter, zero-run counter, LED index
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shift    <= '0;
            r_bitcnt   <= '0;
            r_zrun     <= '0;
            r_word_vld <= 1'b0;
            r_idx      <= '0;
        end else begin
            if (w_stb) begin
                r_shift  <= {r_shift[FRAME_BITS-2:0], w_bit};
                r_bitcnt <= w_start ? 5'd0 : r_bitcnt + 5'd1;
            end
            r_word_vld <= w_stb && (r_state == LEDS) && (r_bitcnt == 5'd31);

            // Zero run only matters while hunting; restart it on every re-entry.
            if (r_state != HUNT)
                r_zrun <= '0;
            else if (w_stb)
                r_zrun <= w_bit ? 6'd0 : ((r_zrun == 6'd32) ? 6'd32 : r_zrun + 6'd1);

            if (w_idx_clr)      r_idx <= '0;
            else if (w_idx_inc) r_idx <= r_idx + 1'b1;
        end
    end

    assign w_hs = r_valid & pix_ready;

    // One-entry holding register and status flags. Error sets beat clear_err.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pix     <= '0;
            r_pix_idx <= '0;
            r_valid   <= 1'b0;
            r_done    <= 1'b0;
            r_hdr_err <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            if (w_load && (!r_valid || w_hs)) begin
                r_pix     <= word_to_pixel(r_shift);
                r_pix_idx <= r_idx;
                r_valid   <= 1'b1;
            end else if (w_hs) begin
                r_valid <= 1'b0;
            end

            r_done <= w_done;

            if (w_hdr)          r_hdr_err <= 1'b1;
            else if (clear_err) r_hdr_err <= 1'b0;

            if (w_load && r_valid && !w_hs) r_ovf <= 1'b1;
            else if (clear_err)             r_ovf <= 1'b0;
        end
    end

    assign pix_valid  = r_valid;
    assign pix_index  = r_pix_idx;
    assign pix_bright = r_pix.bright;
    assign pix_blue   = r_pix.blue;
    assign pix_green  = r_pix.green;
    assign pix_red    = r_pix.red;
    assign frame_done = r_done;
    assign hdr_err    = r_hdr_err;
    assign overflow   = r_ovf;

endmodule

// File: tb/tb_apa102_frame_rx.sv
// tb_apa102_frame_rx: directed + randomized bench for apa102_frame_rx with a
// word-level reference model of the stream decoder.
module tb_apa102_frame_rx;

    localparam int NL = 64;
    localparam int SS = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       led_clk_i = 1'b0;
    logic       led_data_i = 1'b0;
    logic       pix_ready = 1'b1;
    logic       clear_err = 1'b0;
    logic       pix_valid;
    logic [5:0] pix_index;
    logic [4:0] pix_bright;
    logic [7:0] pix_blue, pix_green, pix_red;
    logic       frame_done, hdr_err, overflow;

    always #5 clk = ~clk;

    apa102_frame_rx #(.NUM_LEDS(NL), .SYNC_STAGES(SS)) dut (
        .clk        (clk),
        .reset      (reset),
        .led_clk_i  (led_clk_i),
        .led_data_i (led_data_i),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_index  (pix_index),
        .pix_bright (pix_bright),
        .pix_blue   (pix_blue),
        .pix_green  (pix_green),
        .pix_red    (pix_red),
        .frame_done (frame_done),
        .hdr_err    (hdr_err),
        .overflow   (overflow),
        .clear_err  (clear_err)
    );

    typedef struct packed {
        logic [7:0] idx;
        logic [4:0] br;
        logic [7:0] b;
        logic [7:0] g;
        logic [7:0] r;
    } px_t;

    int  checks = 0;
    int  errors = 0;
    px_t exp_q[$];
    px_t got_q[$];
    int  exp_done = 0;
    int  got_done = 0;
    bit  exp_hdr = 1'b0;

    // reference model state
    bit          m_hunt = 1'b1;
    int          m_zeros = 0;
    int          m_nbits = 0;
    int          m_idx = 0;
    logic [31:0] m_word = '0;

    always @(negedge clk) begin
        if (pix_valid && pix_ready)
            got_q.push_back('{idx: 8'(pix_index), br: pix_bright, b: pix_blue, g: pix_green, r: pix_red});
        if (frame_done) got_done++;
    end

    function automatic px_t word_px(input logic [31:0] w, input int idx);
        px_t p;
        p.idx = 8'(idx);
        p.br  = w[28:24];
        p.b   = w[23:16];
        p.g   = w[15:8];
        p.r   = w[7:0];
        return p;
    endfunction

    function automatic px_t pix_now();
        return '{idx: 8'(pix_index), br: pix_bright, b: pix_blue, g: pix_green, r: pix_red};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_hunt = 1'b1; m_zeros = 0; m_nbits = 0; m_idx = 0; m_word = '0;
    endtask

    // Stream rules: 32 consecutive zeros align; then each 32-bit word is an
    // LED frame (111 header), a zero word (end/start frame), or an error.
    task automatic model_bit(input bit b);
        if (m_hunt) begin
            if (!b) begin
                m_zeros++;
                if (m_zeros == 32) begin
                    m_hunt = 1'b0; m_nbits = 0; m_idx = 0;
                end
            end else begin
                m_zeros = 0;
            end
        end else begin
            m_word = {m_word[30:0], b};
            m_nbits++;
            if (m_nbits == 32) begin
                m_nbits = 0;
                if (m_word[31:29] == 3'b111) begin
                    exp_q.push_back(word_px(m_word, m_idx));
                    if (m_idx == NL - 1) begin
                        exp_done++; m_hunt = 1'b1; m_zeros = 0; m_idx = 0;
                    end else begin
                        m_idx++;
                    end
                end else if (m_word == 32'h0) begin
                    if (m_idx > 0) exp_done++;
                    m_idx = 0;
                end else begin
                    exp_hdr = 1'b1; m_hunt = 1'b1; m_zeros = 0; m_idx = 0;
                end
            end
        end
    endtask

    // Called aligned to a clk negedge; returns aligned to a negedge.
    task automatic send_bit(input bit b);
        led_data_i = b;
        @(negedge clk); led_clk_i = 1'b1;
        repeat (4) @(negedge clk);
        led_clk_i = 1'b0;
        repeat (4) @(negedge clk);
        model_bit(b);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 31; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic send_zeros(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b0);
    endtask

    // Last bit is hand-timed: optionally checks the rise latency of pix_valid
    // and/or raises pix_ready so the handshake lands on the load edge.
    task automatic send_word_timed(input logic [31:0] w, input bit lat_chk, input bit rdy_on_load);
        px_t exp_px;
        for (int i = 31; i >= 1; i--) send_bit(w[i]);
        exp_px = word_px(w, m_idx);
        led_data_i = w[0];
        @(negedge clk); led_clk_i = 1'b1;
        repeat (SS + 2) @(posedge clk);
        #1;
        if (lat_chk) check("lat_early", 64'(pix_valid), 64'(1'b0));
        if (rdy_on_load) pix_ready = 1'b1;
        @(posedge clk); #1;
        if (lat_chk) check("lat_rise", 64'(pix_valid), 64'(1'b1));
        if (rdy_on_load) begin
            check("same_cyc_valid", 64'(pix_valid), 64'(1'b1));
            check("same_cyc_pix", 64'(pix_now()), 64'(exp_px));
        end
        @(negedge clk); led_clk_i = 1'b0;
        repeat (4) @(negedge clk);
        model_bit(w[0]);
    endtask

    task automatic compare(input string tag);
        repeat (20) @(negedge clk);
        check({tag, "_npix"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check({tag, "_pix"}, 64'(got_q[i]), 64'(exp_q[i]));
        check({tag, "_done"}, 64'(got_done), 64'(exp_done));
        check({tag, "_hdr"}, 64'(hdr_err), 64'(exp_hdr));
        got_q.delete(); exp_q.delete();
        got_done = 0; exp_done = 0;
    endtask

    task automatic pulse_clear();
        @(posedge clk); #1 clear_err = 1'b1;
        @(posedge clk); #1 clear_err = 1'b0;
        exp_hdr = 1'b0;
        @(negedge clk);
    endtask

    task automatic set_ready(input bit v);
        @(posedge clk); #1 pix_ready = v;
        @(negedge clk);
    endtask

    logic [31:0] words[NL];
    logic [31:0] tmp;
    px_t         held;

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        check("rst_valid", 64'(pix_valid), 64'(0));
        check("rst_index", 64'(pix_index), 64'(0));
        check("rst_fields", 64'({pix_bright, pix_blue, pix_green, pix_red}), 64'(0));
        check("rst_flags", 64'({frame_done, hdr_err, overflow}), 64'(0));
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // bring-up with exact latency on the first pixel
        send_zeros(32);
        send_word_timed(32'hF00F0000, 1'b1, 1'b0);
        send_word(32'hF0000000);
        repeat (10) @(negedge clk);
        check("bring_px0", 64'(got_q[0]), 64'(px_t'{8'd0, 5'h10, 8'h0F, 8'h00, 8'h00}));
        check("bring_px1", 64'(got_q[1]), 64'(px_t'{8'd1, 5'h10, 8'h00, 8'h00, 8'h00}));
        compare("bring");

        // two full refreshes with random colours
        for (int i = 0; i < NL; i++) begin
            tmp = $urandom();
            words[i] = {3'b111, tmp[28:0]};
        end
        for (int rf = 0; rf < 2; rf++) begin
            send_zeros(32);
            for (int i = 0; i < NL; i++) send_word(words[i]);
            send_zeros(64);
            compare(rf == 0 ? "refresh0" : "refresh1");
        end

        // bad header, recovery, clear
        send_zeros(32);
        send_word(32'h5A000000);
        compare("badhdr");
        send_zeros(32);
        send_word(32'hFFFFFFFF);
        repeat (10) @(negedge clk);
        check("recover_px", 64'(got_q[0]), 64'(px_t'{8'd0, 5'h1F, 8'hFF, 8'hFF, 8'hFF}));
        compare("recover");
        pulse_clear();
        check("hdr_cleared", 64'(hdr_err), 64'(0));

        // backpressure: first pixel held, second dropped
        send_zeros(32);
        set_ready(1'b0);
        tmp = $urandom(); send_word({3'b111, tmp[28:0]});
        held = exp_q[0];
        check("bp_valid", 64'(pix_valid), 64'(1));
        check("bp_hold0", 64'(pix_now()), 64'(held));
        check("bp_ovf0", 64'(overflow), 64'(0));
        tmp = $urandom(); send_word({3'b111, tmp[28:0]});
        check("bp_hold1", 64'(pix_now()), 64'(held));
        check("bp_ovf1", 64'(overflow), 64'(1));
        void'(exp_q.pop_back()); // second pixel never reaches the consumer
        set_ready(1'b1);
        compare("bp");
        pulse_clear();
        check("ovf_cleared", 64'(overflow), 64'(0));

        // same-cycle handshake and load
        set_ready(1'b0);
        tmp = $urandom(); send_word({3'b111, tmp[28:0]});
        tmp = $urandom(); send_word_timed({3'b111, tmp[28:0]}, 1'b0, 1'b1);
        check("same_cyc_ovf", 64'(overflow), 64'(0));
        compare("samecyc");

        // reset in the middle of a word with a pixel pending
        set_ready(1'b0);
        tmp = $urandom(); send_word({3'b111, tmp[28:0]});
        tmp = $urandom();
        for (int i = 31; i >= 16; i--) send_bit(tmp[i] | (i == 31));
        check("pre_rst_valid", 64'(pix_valid), 64'(1));
        reset = 1'b0;
        #1;
        check("mid_rst_valid", 64'(pix_valid), 64'(0));
        check("mid_rst_index", 64'(pix_index), 64'(0));
        check("mid_rst_fields", 64'({pix_bright, pix_blue, pix_green, pix_red}), 64'(0));
        check("mid_rst_flags", 64'({frame_done, hdr_err, overflow}), 64'(0));
        model_reset();
        exp_q.delete(); got_q.delete(); exp_done = 0; got_done = 0; exp_hdr = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        set_ready(1'b1);

        // misaligned preamble then a clean start frame
        for (int i = 0; i < 7; i++) send_bit(1'b1);
        send_zeros(20);
        send_bit(1'b1);
        send_zeros(32);
        send_word(32'hE1020304);
        repeat (10) @(negedge clk);
        check("mis_npix", 64'(got_q.size()), 64'(1));
        check("mis_px", 64'(got_q[0]), 64'(px_t'{8'd0, 5'd1, 8'd2, 8'd3, 8'd4}));
        compare("misalign");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/apa102_frame_rx.md
# apa102_frame_rx

Receive-side counterpart of the matrix LED-strip driver. The block samples an APA102-style two-wire stream (serial clock and data, MSB first) on the system clock and finds the 32-bit all-zero start frame. It decodes each following 32-bit LED frame (3'b111 header, 5-bit brightness, blue, green, red) and presents one pixel per frame on a valid/ready port with its LED index. It is used on-chip as a loopback checker for the driver and as a front end for a pixel-capture or mirror display.

## Interface
Parameters:
- NUM_LEDS, 64: LED frames per refresh. Index width is IDX_W = $clog2(NUM_LEDS).
- SYNC_STAGES, 2: synchronizer depth on led_clk_i and led_data_i. Minimum is 2.

Ports:
- clk  input  1  system clock; all state on its rising edge.
- reset  input  1  asynchronous, active-low reset; deassertion synchronous to clk.
- led_clk_i  input  1  serial strip clock, asynchronous to clk.
- led_data_i  input  1  serial strip data, sampled at the rising edge of led_clk_i.
- pix_valid  output  1  pixel holding register full.
- pix_ready  input  1  consumer accepts the pixel when pix_valid && pix_ready.
- pix_index  output  IDX_W  LED position within the refresh, 0 = first frame after the start frame.
- pix_bright  output  5  global-brightness field.
- pix_blue / pix_green / pix_red  output  8 each  colour fields.
- frame_done  output  1  one-cycle pulse when a refresh ends.
- hdr_err  output  1  sticky; an LED word lacked the 3'b111 header.
- overflow  output  1  sticky; a pixel was dropped because the holding register was full.
- clear_err  input  1  synchronous clear of hdr_err and overflow.

## Operation
- led_clk_i and led_data_i pass through identical SYNC_STAGES flop chains. A rising edge is detected when the synced clock is 1 and its previous value was 0. On that cycle the synced data bit shifts into a 32-bit shift register, MSB first, and the bit counter advances modulo 32.
- **HUNT** (reset state)
  - A 6-bit zero-run counter increments on each 0 bit and clears on each 1 bit; it saturates at 32.
  - On the 32nd consecutive zero: clear the bit counter and LED index, then go to LEDS. Word alignment is set here.
- **LEDS**, on each 32nd bit (word complete):
  - word[31:29] == 3'b111: load the pixel register with {index, word[28:24], word[23:16], word[15:8], word[7:0]}, then increment the index. If the index was NUM_LEDS-1: pulse frame_done, go to HUNT.
  - word == 0: if index > 0, pulse frame_done. Clear the index and stay in LEDS. This covers the end frame followed by the next start frame.
  - anything else: set hdr_err, clear the index, go to HUNT. No frame_done.
- **Holding register** (one entry):
  - A pixel load with the register full and no handshake that cycle: set overflow, drop the new pixel, keep the old one.
  - A load in the same cycle as a handshake: the old pixel is consumed and the new one loaded; pix_valid stays 1.
- clear_err and a same-cycle error event: the set wins.
- Reset mid-stream: all state clears. The partially received refresh is lost and resynchronisation needs a fresh 32-zero run.

## Timing
- Reset values:
  - pix_valid=0, pix_index=0, all colour and brightness fields 0.
  - frame_done=0, hdr_err=0, overflow=0.
  - State HUNT, counters 0, synchronizer flops 0.
- Latency: pix_valid rises exactly SYNC_STAGES+2 clk cycles after the clk edge that first samples the 32nd led_clk_i rise of the word (4 cycles at default). frame_done and hdr_err have the same latency.
- pix_valid and the pixel fields are registered and held stable until the handshake. pix_valid may drop the cycle after the handshake.
- led_clk_i high and low phases must each be ≥ SYNC_STAGES+1 clk periods. Data must be stable from before the led_clk_i rise until after it. Violations give undefined data but no lockup; the next 32-zero run recovers.

## Structure
- Package apa102_pkg holds:
  - FRAME_BITS=32 and LED_HDR=3'b111.
  - Field bit positions.
  - The pixel struct typedef {bright, blue, green, red}.
  - The state enum {HUNT, LEDS}.
- Sub-module apa102_edge_sync holds the parameterised synchronizer for both inputs plus the rising-edge detector. Its outputs are the synced data and a one-cycle sample strobe.
- The top level holds the FSM, shift register, counters and the holding register.

## Test plan
- Bring-up: 32 zero bits, then LED frames 0xF00F0000 and 0xF0000000, pix_ready=1. Expected pixels: index 0 with bright=0x10, blue=0x0F; then index 1 with all colours 0. No errors.
- Full refresh: start frame, 64 LED frames, 64 zero bits. Expected: 64 pixels with indices 0..63, one frame_done pulse after pixel 63, a second refresh decodes identically.
- Bad header: start frame, then word 0x5A000000. Expected: hdr_err=1, no pixel; a later start frame plus 0xFFFFFFFF gives index 0, red=0xFF; clear_err returns hdr_err to 0.
- Backpressure: pix_ready=0 across two LED frames. Expected: the first pixel is held unchanged, overflow=1, the second is dropped. A same-cycle ready and load leaves pix_valid=1 with the new pixel.
- Misalignment: 7 ones, 20 zeros, 1 one, then 32 zeros and LED frame 0xE1020304. Expected: exactly one pixel, index 0, bright=1, blue=2, green=3, red=4.
- Reset mid-word: assert reset after bit 15 of an LED frame. Expected: all outputs return to reset values immediately, and a new start frame plus word decodes correctly.
